// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-order branch prediction holding queue with resolve/mispredict
// Registers predictor-update and redirect outputs one cycle after EXE resolves the oldest branch.
module branch_resolve_queue #(
    parameter int DEPTH    = 4,
    parameter int CNT_BITS = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq_valid,
    input  logic [31:0]                enq_pc,
    input  logic                       enq_pred_taken,
    input  logic [31:0]                enq_pred_target,
    output logic                       enq_ready,
    input  logic                       res_valid,
    input  logic                       res_taken,
    input  logic [31:0]                res_target,
    input  logic                       flush_in,
    output logic                       upd_valid,
    output logic [31:0]                upd_pc,
    output logic                       upd_taken,
    output logic [31:0]                upd_target,
    output logic                       mispredict,
    output logic [31:0]                redirect_pc,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       underflow_err,
    output logic [CNT_BITS-1:0]        branch_cnt,
    output logic [CNT_BITS-1:0]        mispred_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [31:0]      pc_mem  [DEPTH];
    logic [31:0]      tgt_mem [DEPTH];
    logic [DEPTH-1:0] taken_mem;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    logic        full;
    logic        empty;
    logic        res_fire;
    logic        enq_fire;
    logic        mispredict_now;
    logic [31:0] head_pc;
    logic [31:0] head_tgt;
    logic        head_taken;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign enq_ready  = !full;
    assign head_pc    = pc_mem[head];
    assign head_tgt   = tgt_mem[head];
    assign head_taken = taken_mem[head];
    assign res_fire   = res_valid && !empty;

    // Target only matters when the branch is actually taken.
    assign mispredict_now = res_fire &&
                            ((res_taken != head_taken) || (res_taken && (res_target != head_tgt)));

    assign enq_fire = enq_valid && enq_ready && !flush_in && !mispredict_now;

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            pc_mem[tail]    <= enq_pc;
            tgt_mem[tail]   <= enq_pred_target;
            taken_mem[tail] <= enq_pred_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            upd_valid     <= 1'b0;
            upd_pc        <= 32'h0;
            upd_taken     <= 1'b0;
            upd_target    <= 32'h0;
            mispredict    <= 1'b0;
            redirect_pc   <= 32'h0;
            underflow_err <= 1'b0;
            branch_cnt    <= '0;
            mispred_cnt   <= '0;
        end else begin
            upd_valid  <= res_fire;
            mispredict <= mispredict_now && !flush_in;

            if (res_fire) begin
                upd_pc      <= head_pc;
                upd_taken   <= res_taken;
                upd_target  <= res_target;
                redirect_pc <= res_taken ? res_target : head_pc + 32'd4;
                if (branch_cnt != '1)
                    branch_cnt <= branch_cnt + CNT_BITS'(1);
                if (mispredict_now && (mispred_cnt != '1))
                    mispred_cnt <= mispred_cnt + CNT_BITS'(1);
            end

            if (res_valid && empty)
                underflow_err <= 1'b1;

            // A mispredict squashes every younger entry, so the queue simply empties.
            if (flush_in || mispredict_now) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (res_fire)
                    head <= head + PTR_W'(1);
                if (enq_fire)
                    tail <= tail + PTR_W'(1);
                case ({enq_fire, res_fire})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule
